// File: rtl/lc3b_types.sv
// Shared constants and types for LC-3b pipeline stage registers.
package lc3b_types;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 3;

  typedef logic [31:0] lc3b_ipacket;
  localparam int PKT_W = $bits(lc3b_ipacket);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } lc3b_stage_state_t;

  // Layout matches the flat {words, ipacket} vector the stage stores.
  typedef struct packed {
    logic [NUM_WORDS*WORD_W-1:0] words;
    lc3b_ipacket                 ipacket;
  } lc3b_entry_t;

endpackage

// File: rtl/lc3b_pipe_stage_if.sv
// Ready/valid bus between two adjacent LC-3b pipeline stages.
interface lc3b_pipe_stage_if #(
  parameter int NUM_WORDS = lc3b_types::NUM_WORDS,
  parameter int WORD_W    = lc3b_types::WORD_W,
  parameter int PKT_W     = lc3b_types::PKT_W
);
  logic                        in_valid;
  logic                        in_ready;
  logic [PKT_W-1:0]            in_ipacket;
  logic [NUM_WORDS*WORD_W-1:0] in_words;
  logic                        out_valid;
  logic                        out_ready;
  logic [PKT_W-1:0]            out_ipacket;
  logic [NUM_WORDS*WORD_W-1:0] out_words;

  modport master (
    output in_valid, in_ipacket, in_words, out_ready,
    input  in_ready, out_valid, out_ipacket, out_words
  );

  modport slave (
    input  in_valid, in_ipacket, in_words, out_ready,
    output in_ready, out_valid, out_ipacket, out_words
  );
endinterface

// File: rtl/lc3b_stage_entry.sv
// One held pipeline entry: load enable, async reset, synchronous clear.
module lc3b_stage_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: storage is reset so no stale packet can ever reach the zero mask
  // inputs after reset; sequential state uses <= so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/lc3b_pipe_stage.sv
// Pipeline stage register with ready/valid handshake, optional skid entry,
// synchronous flush and a saturating back-pressure counter.
module lc3b_pipe_stage #(
  parameter int NUM_WORDS = lc3b_types::NUM_WORDS,
  parameter int WORD_W    = lc3b_types::WORD_W,
  parameter int PKT_W     = lc3b_types::PKT_W,
  parameter int SKID      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  lc3b_pipe_stage_if.slave    bus,
  output logic [15:0]         stall_cycles
);
  import lc3b_types::*;

  localparam int WORDS_W = NUM_WORDS * WORD_W;
  localparam int ENTRY_W = WORDS_W + PKT_W;

  lc3b_stage_state_t    state, state_nxt;
  logic                 xfer_in, xfer_out;
  logic                 head_load, skid_load, head_from_skid;
  logic [ENTRY_W-1:0]   in_entry, head_d, head_q, skid_q;

  assign bus.out_valid = (state != EMPTY);
  assign xfer_in       = bus.in_valid && bus.in_ready;
  assign xfer_out      = bus.out_valid && bus.out_ready;
  assign in_entry      = {bus.in_words, bus.in_ipacket};

  // With a skid entry the ready path is registered; without it, a full
  // stage can only accept when the head leaves in the same cycle.
  always_comb begin
    if (SKID != 0) bus.in_ready = (state != TWO);
    else           bus.in_ready = (state == EMPTY) || bus.out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      EMPTY: if (xfer_in) begin
        state_nxt = ONE;
        head_load = 1'b1;
      end
      ONE: begin
        if (xfer_in && xfer_out) begin
          head_load = 1'b1;
        end else if (xfer_in && SKID != 0) begin
          state_nxt = TWO;
          skid_load = 1'b1;
        end else if (xfer_out) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (xfer_out) begin
        state_nxt      = ONE;
        head_load      = 1'b1;
        head_from_skid = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
    head_d = head_from_skid ? skid_q : in_entry;
  end

  lc3b_stage_entry #(.W(ENTRY_W)) u_head (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  // Without SKID the load never fires, so this register reduces to constants.
  lc3b_stage_entry #(.W(ENTRY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (skid_load),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign bus.out_ipacket = bus.out_valid ? head_q[PKT_W-1:0]       : '0;
  assign bus.out_words   = bus.out_valid ? head_q[ENTRY_W-1:PKT_W] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// Scoreboard bench: SKID=1 and SKID=0 stages share one random stimulus stream.
module tb_lc3b_pipe_stage;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_ipacket = '0;
  logic [47:0] in_words = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3b_pipe_stage_if #(.NUM_WORDS(3), .WORD_W(16), .PKT_W(32)) bus_s ();
  lc3b_pipe_stage_if #(.NUM_WORDS(3), .WORD_W(16), .PKT_W(32)) bus_n ();
  logic [15:0] stall_s, stall_n;

  assign bus_s.in_valid   = in_valid;
  assign bus_s.in_ipacket = in_ipacket;
  assign bus_s.in_words   = in_words;
  assign bus_s.out_ready  = out_ready;
  assign bus_n.in_valid   = in_valid;
  assign bus_n.in_ipacket = in_ipacket;
  assign bus_n.in_words   = in_words;
  assign bus_n.out_ready  = out_ready;

  lc3b_pipe_stage #(.NUM_WORDS(3), .WORD_W(16), .PKT_W(32), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_s), .stall_cycles(stall_s)
  );
  lc3b_pipe_stage #(.NUM_WORDS(3), .WORD_W(16), .PKT_W(32), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus_n), .stall_cycles(stall_n)
  );

  logic        ov [2];
  logic        ir [2];
  logic [31:0] opk [2];
  logic [47:0] ow [2];
  logic [15:0] sc [2];
  assign ov[0] = bus_s.out_valid;   assign ov[1] = bus_n.out_valid;
  assign ir[0] = bus_s.in_ready;    assign ir[1] = bus_n.in_ready;
  assign opk[0] = bus_s.out_ipacket; assign opk[1] = bus_n.out_ipacket;
  assign ow[0] = bus_s.out_words;   assign ow[1] = bus_n.out_words;
  assign sc[0] = stall_s;           assign sc[1] = stall_n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid) per stage,
  // plus a saturating count of cycles where something was held but not taken.
  lc3b_entry_t mq [2][2];
  int          mn [2];
  int          mcnt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      string tag;
      bit    exp_rdy;
      tag = (d == 0) ? "skid" : "noskid";
      if (rst) begin
        check({tag, " rst in_ready"}, 64'(ir[d]), 64'd1);
        check({tag, " rst out_valid"}, 64'(ov[d]), 64'd0);
        check({tag, " rst stall"}, 64'(sc[d]), 64'd0);
        mn[d] = 0;
        mcnt[d] = 0;
        continue;
      end
      exp_rdy = (d == 0) ? (mn[d] < 2) : (mn[d] == 0 || out_ready);
      check({tag, " in_ready"}, 64'(ir[d]), 64'(exp_rdy));
      check({tag, " out_valid"}, 64'(ov[d]), 64'(mn[d] != 0));
      if (mn[d] != 0) begin
        check({tag, " out_ipacket"}, 64'(opk[d]), 64'(mq[d][0].ipacket));
        check({tag, " out_words"}, 64'(ow[d]), 64'(mq[d][0].words));
      end else begin
        check({tag, " bubble ipacket"}, 64'(opk[d]), 64'd0);
        check({tag, " bubble words"}, 64'(ow[d]), 64'd0);
      end
      check({tag, " stall_cycles"}, 64'(sc[d]), 64'(mcnt[d]));
      if (mn[d] != 0 && !out_ready && mcnt[d] < 65535) mcnt[d]++;
      if (mn[d] != 0 && out_ready) begin
        mq[d][0] = mq[d][1];
        mn[d]--;
      end
      if (flush) mn[d] = 0;
      else if (in_valid && exp_rdy) begin
        mq[d][mn[d]].ipacket = in_ipacket;
        mq[d][mn[d]].words   = in_words;
        mn[d]++;
      end
    end
  end

  task automatic step(input bit v, input bit r, input bit f);
    in_valid   = v;
    out_ready  = r;
    flush      = f;
    in_ipacket = $urandom;
    in_words   = {16'($urandom), $urandom};
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0; flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single transfer followed by a bubble.
    in_valid = 1'b1; out_ready = 1'b1;
    in_ipacket = 32'h1234; in_words = {16'h0003, 16'h0002, 16'h0001};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: A and B held, C offered until there is room.
    step(1, 0, 0); step(1, 0, 0);
    repeat (3) step(1, 0, 0);
    repeat (6) step(0, 1, 0);

    // Streaming at full rate.
    repeat (100) step(1, 1, 0);
    repeat (3) step(0, 1, 0);

    // Flush with two held entries and a new input offered.
    step(1, 0, 0); step(1, 0, 0);
    step(1, 0, 1);
    repeat (4) step(0, 1, 0);

    // Random traffic with occasional flushes.
    repeat (400) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 40) == 0);

    // out_ready toggling every cycle while input is always offered.
    for (int i = 0; i < 60; i++) step(1, i[0], 0);
    repeat (3) step(0, 1, 0);

    // Asynchronous reset in the middle of a cycle with entries held.
    step(1, 0, 0); step(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst skid out_valid", 64'(ov[0]), 64'd0);
    check("async rst noskid out_valid", 64'(ov[1]), 64'd0);
    check("async rst skid out_ipacket", 64'(opk[0]), 64'd0);
    check("async rst skid in_ready", 64'(ir[0]), 64'd1);
    check("async rst noskid stall", 64'(sc[1]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Saturation of the back-pressure counter.
    pulse_reset();
    step(1, 0, 0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("saturate skid stall", 64'(sc[0]), 64'hFFFF);
    check("saturate noskid stall", 64'(sc[1]), 64'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check("saturate skid stall hold", 64'(sc[0]), 64'hFFFF);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
